// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO for a UART receiver.
// Each entry holds one character plus its framing/parity error flag. The flag
// travels with the character so the consumer sees the error on the same word.
// A sticky overflow flag records characters dropped while the FIFO was full.
module uart_rx_fifo #(
  parameter int DATA_WIDTH      = 8,
  parameter int CHARACTER_COUNT = 16,
  parameter int AFULL_LEVEL     = 12
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 ena,
  input  logic [DATA_WIDTH-1:0]                rx_data_in,
  input  logic                                 rx_data_in_valid,
  input  logic                                 rx_err_in,
  output logic [DATA_WIDTH-1:0]                rx_data,
  output logic                                 rx_err,
  output logic                                 rx_valid,
  input  logic                                 rx_ready,
  output logic [$clog2(CHARACTER_COUNT+1)-1:0] count,
  output logic                                 empty,
  output logic                                 full,
  output logic                                 almost_full,
  output logic                                 overflow,
  input  logic                                 overflow_clr
);

  localparam int PW = $clog2(CHARACTER_COUNT);
  localparam int CW = $clog2(CHARACTER_COUNT + 1);
  localparam int EW = DATA_WIDTH + 1;

  localparam logic [PW-1:0] LAST_PTR   = PW'(CHARACTER_COUNT - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(CHARACTER_COUNT);
  localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_LEVEL);

  logic [EW-1:0] r_mem [CHARACTER_COUNT];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_head;

  // Status flags come straight from the registered occupancy; a push is still
  // accepted when full as long as the head leaves in the same cycle.
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == FULL_COUNT);
    w_valid = ena && !w_empty;
    w_pop   = w_valid && rx_ready;
    w_push  = ena && rx_data_in_valid && (!w_full || w_pop);
    w_drop  = ena && rx_data_in_valid && w_full && !w_pop;
    w_head  = r_mem[r_rd_ptr];
  end

  // Storage array; cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHARACTER_COUNT; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {rx_err_in, rx_data_in};
    end
  end

  // Write and read pointers, wrapping at the last entry (depth need not be a power of two).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
    end
  end

  // Occupancy: moves only when exactly one of push/pop happens.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign rx_data     = w_head[DATA_WIDTH-1:0];
  assign rx_err      = w_head[DATA_WIDTH];
  assign rx_valid    = w_valid;
  assign count       = r_count;
  assign empty       = w_empty;
  assign full        = w_full;
  assign almost_full = (r_count >= AFULL_CNT);
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo with default parameters (8-bit, depth 16,
// almost_full at 12). Inputs change 1 ns after the rising edge; outputs are
// checked at that point, after registered state has settled.
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset_n;
  logic       ena;
  logic [7:0] rx_data_in;
  logic       rx_data_in_valid;
  logic       rx_err_in;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       rx_valid;
  logic       rx_ready;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       overflow;
  logic       overflow_clr;

  int n_chk  = 0;
  int n_pass = 0;

  uart_rx_fifo #(
    .DATA_WIDTH(8),
    .CHARACTER_COUNT(16),
    .AFULL_LEVEL(12)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ena(ena),
    .rx_data_in(rx_data_in),
    .rx_data_in_valid(rx_data_in_valid),
    .rx_err_in(rx_err_in),
    .rx_data(rx_data),
    .rx_err(rx_err),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .count(count),
    .empty(empty),
    .full(full),
    .almost_full(almost_full),
    .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    rx_data_in       = d;
    rx_err_in        = e;
    rx_data_in_valid = 1'b1;
    tick();
    rx_data_in_valid = 1'b0;
    rx_err_in        = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] d, input logic e);
    chk({tag, "_valid"}, int'(rx_valid), 1);
    chk({tag, "_data"}, int'(rx_data), int'(d));
    chk({tag, "_err"}, int'(rx_err), int'(e));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic fill16(input logic [7:0] base);
    for (int i = 0; i < 16; i++) push(base + 8'(i), 1'b0);
  endtask

  initial begin
    reset_n          = 1'b0;
    ena              = 1'b1;
    rx_data_in       = '0;
    rx_data_in_valid = 1'b0;
    rx_err_in        = 1'b0;
    rx_ready         = 1'b0;
    overflow_clr     = 1'b0;
    tick();
    tick();

    // reset values
    chk("rst_valid", int'(rx_valid), 0);
    chk("rst_data", int'(rx_data), 0);
    chk("rst_err", int'(rx_err), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_afull", int'(almost_full), 0);
    chk("rst_ovf", int'(overflow), 0);
    reset_n = 1'b1;
    tick();

    // single character, one-cycle latency, then pop
    push(8'h41, 1'b0);
    chk("one_valid", int'(rx_valid), 1);
    chk("one_data", int'(rx_data), 'h41);
    chk("one_count", int'(count), 1);
    chk("one_empty", int'(empty), 0);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("one_pop_valid", int'(rx_valid), 0);
    chk("one_pop_count", int'(count), 0);

    // fill to full, check thresholds, drop one, drain in order
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 1'b0);
      chk("fill_count", int'(count), i + 1);
      chk("fill_afull", int'(almost_full), (i + 1 >= 12) ? 1 : 0);
      chk("fill_full", int'(full), (i + 1 == 16) ? 1 : 0);
    end
    chk("pre_drop_ovf", int'(overflow), 0);
    push(8'hAA, 1'b0);
    chk("drop_ovf", int'(overflow), 1);
    chk("drop_count", int'(count), 16);
    for (int i = 0; i < 16; i++) pop_chk("drain", 8'(i), 1'b0);
    chk("drain_empty", int'(empty), 1);
    chk("drain_valid", int'(rx_valid), 0);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("clr_ovf", int'(overflow), 0);

    // full with simultaneous strobe and pop
    fill16(8'h10);
    rx_data_in       = 8'h55;
    rx_data_in_valid = 1'b1;
    rx_ready         = 1'b1;
    tick();
    rx_data_in_valid = 1'b0;
    rx_ready         = 1'b0;
    chk("fullpp_count", int'(count), 16);
    chk("fullpp_ovf", int'(overflow), 0);
    for (int i = 1; i < 16; i++) pop_chk("fullpp", 8'h10 + 8'(i), 1'b0);
    pop_chk("fullpp_last", 8'h55, 1'b0);
    chk("fullpp_empty", int'(empty), 1);

    // push 10, pop 10, push 10, pop 10 across pointer wrap
    for (int i = 0; i < 10; i++) push(8'h20 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) pop_chk("wrap_a", 8'h20 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) push(8'h80 + 8'(i), 1'b0);
    chk("wrap_count", int'(count), 10);
    for (int i = 0; i < 10; i++) pop_chk("wrap_b", 8'h80 + 8'(i), 1'b0);
    chk("wrap_empty", int'(empty), 1);

    // error flag travels with its character
    push(8'h33, 1'b1);
    push(8'h34, 1'b0);
    pop_chk("err1", 8'h33, 1'b1);
    pop_chk("err0", 8'h34, 1'b0);

    // overflow set, clear with simultaneous drop keeps it, clear alone clears
    fill16(8'hC0);
    push(8'hEE, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    overflow_clr = 1'b1;
    push(8'hEF, 1'b0);
    chk("ovf_set_wins", int'(overflow), 1);
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr", int'(overflow), 0);
    chk("ovf_count", int'(count), 16);
    for (int i = 0; i < 16; i++) pop_chk("ovf_drain", 8'hC0 + 8'(i), 1'b0);

    // disabled: strobes and pops ignored, no overflow even when full
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 1'b0);
    ena              = 1'b0;
    rx_data_in       = 8'h77;
    rx_data_in_valid = 1'b1;
    rx_ready         = 1'b1;
    #1;
    chk("dis_valid_comb", int'(rx_valid), 0);
    tick();
    tick();
    chk("dis_count", int'(count), 5);
    chk("dis_ovf", int'(overflow), 0);
    rx_data_in_valid = 1'b0;
    rx_ready         = 1'b0;
    ena              = 1'b1;
    chk("dis_head", int'(rx_data), 'h60);

    // asynchronous reset with 5 stored entries
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_valid", int'(rx_valid), 0);
    chk("arst_empty", int'(empty), 1);
    tick();
    reset_n = 1'b1;
    tick();
    push(8'h99, 1'b0);
    chk("post_rst_count", int'(count), 1);
    pop_chk("post_rst", 8'h99, 1'b0);
    chk("post_rst_empty", int'(empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
